// File: rtl/size_hdr_pkg.sv
// Shared definitions for the size header receiver and its size_count neighbours.
package size_hdr_pkg;

    localparam int unsigned SYNC_W = 8;
    localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;
    localparam int unsigned SIZE_W = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        StHunt,
        StSize,
        StParity,
        StIssue,
        StPayload
    } state_t;

endpackage

// File: rtl/sync_detect.sv
// Sync-word shift register and comparator; match includes the bit presented this cycle.
module sync_detect #(
    parameter int unsigned SYNC_W = size_hdr_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = size_hdr_pkg::SYNC_WORD
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic match
);
    import size_hdr_pkg::*;

    logic [SYNC_W-1:0] shift_q;
    logic [SYNC_W-1:0] shift_d;

    assign shift_d = {shift_q[SYNC_W-2:0], bit_in};
    assign match   = enable && (shift_d == SYNC_WORD);

    always_ff @(posedge clock) begin
        if (rst || clear) begin
            shift_q <= '0;
        end else if (enable) begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/size_header_rx.sv
// Hunts a serial stream for SYNC_WORD, deserializes the size field and forwards the payload
// until last. Define SIZE_HDR_PARITY_EN to add an even-parity bit after the size field.
module size_header_rx #(
    parameter int unsigned SYNC_W = size_hdr_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = size_hdr_pkg::SYNC_WORD,
    parameter int unsigned SIZE_W = size_hdr_pkg::SIZE_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              serial_valid,
    input  logic              last,
    output logic [SIZE_W-1:0] size,
    output logic              size_valid,
    output logic              data_start,
    output logic              data_out,
    output logic              data_valid,
    output logic              hdr_err,
    output logic              busy
);
    import size_hdr_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE_W - 1);

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] size_sr_q, size_out_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              size_valid_q, size_valid_d;
    logic              hdr_err_q, hdr_err_d;
    logic              data_start_q, data_start_d;
    logic              data_valid_q, data_valid_d;
    logic              data_out_q;
    logic              sync_match, sync_clear, size_zero, parity_ok, size_done;

    assign size_zero = (size_sr_q == '0);
    assign parity_ok = ~^{size_sr_q, serial_in};
    assign size_done = (state_q == StSize) && serial_valid && (cnt_q == LAST_CNT);
    // Clearing on match too means a rejected header resumes hunting from a clean window.
    assign sync_clear = sync_match || ((state_q == StPayload) && last);

    sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clock  (clock),
        .rst    (rst),
        .clear  (sync_clear),
        .enable ((state_q == StHunt) && serial_valid),
        .bit_in (serial_in),
        .match  (sync_match)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt:    if (sync_match) state_d = StSize;
`ifdef SIZE_HDR_PARITY_EN
            StSize:    if (size_done) state_d = StParity;
`else
            StSize:    if (size_done) state_d = StIssue;
`endif
            StParity:  if (serial_valid) state_d = parity_ok ? StIssue : StHunt;
            StIssue:   state_d = size_zero ? StHunt : StPayload;
            StPayload: if (last) state_d = StHunt;
            default:   state_d = StHunt;
        endcase
    end

    always_comb begin
        size_valid_d = (state_q == StIssue) && !size_zero;
        hdr_err_d    = (state_q == StIssue) && size_zero;
`ifdef SIZE_HDR_PARITY_EN
        if ((state_q == StParity) && serial_valid && !parity_ok) begin
            hdr_err_d = 1'b1;
        end
`endif
        // data_start lags the PAYLOAD state by a cycle so it never overlaps size_valid.
        data_start_d = (state_q == StPayload) && !last;
        data_valid_d = (state_q == StPayload) && serial_valid;
        busy         = (state_q != StHunt);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            size_sr_q    <= '0;
            size_out_q   <= '0;
            cnt_q        <= '0;
            size_valid_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            data_start_q <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= 1'b0;
        end else begin
            size_valid_q <= size_valid_d;
            hdr_err_q    <= hdr_err_d;
            data_start_q <= data_start_d;
            data_valid_q <= data_valid_d;
            if (data_valid_d) begin
                data_out_q <= serial_in;
            end
            if (state_q == StHunt) begin
                cnt_q <= '0;
            end else if ((state_q == StSize) && serial_valid) begin
                size_sr_q <= {size_sr_q[SIZE_W-2:0], serial_in};
                cnt_q     <= cnt_q + 1'b1;
            end
            if (size_valid_d) begin
                size_out_q <= size_sr_q;
            end
        end
    end

    assign size       = size_out_q;
    assign size_valid = size_valid_q;
    assign hdr_err    = hdr_err_q;
    assign data_start = data_start_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_size_header_rx.sv
// Randomized bench for size_header_rx: a stream-level model locates the header and predicts
// size, latency and payload. Build with SIZE_HDR_PARITY_EN to cover the parity variant.
module tb_size_header_rx;
    import size_hdr_pkg::*;

    logic              clock        = 1'b0;
    logic              rst          = 1'b1;
    logic              serial_in    = 1'b0;
    logic              serial_valid = 1'b0;
    logic              last         = 1'b0;
    logic [SIZE_W-1:0] size;
    logic              size_valid, data_start, data_out, data_valid, hdr_err, busy;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned cyc      = 0;

    int unsigned       sv_cnt, err_cnt, sv_cyc, ds_cyc, overlap_cnt;
    bit                ds_seen;
    bit                got_q[$];
    bit                pre_q[$];
    bit                s_q[$];
    logic [SYNC_W-1:0] sync_word = SYNC_WORD;
    logic [SIZE_W-1:0] last_size = '0;

    size_header_rx dut (
        .clock        (clock),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .last         (last),
        .size         (size),
        .size_valid   (size_valid),
        .data_start   (data_start),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .hdr_err      (hdr_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (size_valid) begin
            sv_cnt++;
            sv_cyc = cyc;
        end
        if (hdr_err) err_cnt++;
        if (data_start && !ds_seen) begin
            ds_seen = 1'b1;
            ds_cyc  = cyc;
        end
        if (size_valid && data_start) overlap_cnt++;
        if (data_valid) got_q.push_back(data_out);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        sv_cnt = 0; err_cnt = 0; sv_cyc = 0; ds_cyc = 0; overlap_cnt = 0; ds_seen = 1'b0;
        got_q.delete();
    endtask

    task automatic drive(input bit b, input bit v, input bit l);
        serial_in = b; serial_valid = v; last = l;
        @(posedge clock);
        #1;
    endtask

    task automatic put_bit(input bit b, input bit gap);
        if (gap) repeat ($urandom_range(0, 2)) drive(1'($urandom), 1'b0, 1'b0);
        drive(b, 1'b1, 1'b0);
    endtask

    // Wire stream: prefix, sync word, size MSB first.
    task automatic build_stream(input logic [SIZE_W-1:0] sz);
        s_q = pre_q;
        for (int k = SYNC_W - 1; k >= 0; k--) s_q.push_back(sync_word[k]);
        for (int k = SIZE_W - 1; k >= 0; k--) s_q.push_back(sz[k]);
    endtask

    // Index of the bit completing the first sync word in the stream (history reads as 0).
    function automatic int find_sync();
        logic [SYNC_W-1:0] w;
        for (int i = SYNC_W - 1; i < int'(s_q.size()); i++) begin
            for (int k = 0; k < SYNC_W; k++) w[SYNC_W-1-k] = s_q[i-SYNC_W+1+k];
            if (w == SYNC_WORD) return i;
        end
        return -1;
    endfunction

    function automatic logic [SIZE_W-1:0] model_size(input int pos);
        logic [SIZE_W-1:0] v;
        v = '0;
        for (int k = 0; k < SIZE_W; k++) v[SIZE_W-1-k] = s_q[pos+1+k];
        return v;
    endfunction

    task automatic make_prefix(input int unsigned max_len, input logic [SIZE_W-1:0] sz);
        for (int t = 0; t < 50; t++) begin
            pre_q.delete();
            repeat ($urandom_range(0, max_len)) pre_q.push_back(1'($urandom));
            build_stream(sz);
            if (find_sync() == int'(pre_q.size()) + SYNC_W - 1) return;
        end
        pre_q.delete();
    endtask

    task automatic send_header(input bit gap, input bit par_flip, output int unsigned n_edge);
        bit par;
        par = par_flip;
        for (int i = 0; i < int'(s_q.size()); i++) begin
            put_bit(s_q[i], gap);
            if (i >= int'(pre_q.size()) + SYNC_W) par ^= s_q[i];
        end
        n_edge = cyc;
`ifdef SIZE_HDR_PARITY_EN
        put_bit(par, gap);
        n_edge = cyc;
`endif
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input string tag, input logic [SIZE_W-1:0] sz, input bit gap);
        int                pos;
        int unsigned       n_edge;
        logic [SIZE_W-1:0] exp_sz;
        bit                exp_q[$];
        bit                b;
        logic [63:0]       got_v, exp_v;
        build_stream(sz);
        pos    = find_sync();
        exp_sz = model_size(pos);
        clr_mon();
        send_header(gap, 1'b0, n_edge);
        for (int unsigned i = 0; i < exp_sz; i++) begin
            b = 1'($urandom);
            exp_q.push_back(b);
            if (gap) repeat ($urandom_range(0, 2)) drive(1'($urandom), 1'b0, 1'b0);
            drive(b, 1'b1, i == exp_sz - 1);
        end
        serial_valid = 1'b0;
        last = 1'b0;
        @(negedge clock);
        #1;
        got_v = '0; exp_v = '0;
        for (int i = 0; i < int'(got_q.size()) && i < 64; i++) got_v[i] = got_q[i];
        for (int i = 0; i < int'(exp_q.size()) && i < 64; i++) exp_v[i] = exp_q[i];
        check_eq({tag, " size_valid count"}, 64'(sv_cnt), 64'd1);
        check_eq({tag, " size"}, 64'(size), 64'(exp_sz));
        check_eq({tag, " size_valid cycle"}, 64'(sv_cyc), 64'(n_edge + 1));
        check_eq({tag, " data_start rise cycle"}, 64'(ds_cyc), 64'(n_edge + 2));
        check_eq({tag, " size_valid/data_start overlap"}, 64'(overlap_cnt), 64'd0);
        check_eq({tag, " hdr_err count"}, 64'(err_cnt), 64'd0);
        check_eq({tag, " payload length"}, 64'(got_q.size()), 64'(exp_q.size()));
        check_eq({tag, " payload bits"}, got_v, exp_v);
        check_eq({tag, " data_start/busy after last"}, {62'd0, data_start, busy}, 64'd0);
        last_size = exp_sz;
    endtask

    task automatic run_reject(input string tag, input logic [SIZE_W-1:0] sz, input bit par_flip);
        int unsigned n_edge;
        pre_q.delete();
        build_stream(sz);
        clr_mon();
        send_header(1'b0, par_flip, n_edge);
        @(negedge clock);
        #1;
        check_eq({tag, " hdr_err count"}, 64'(err_cnt), 64'd1);
        check_eq({tag, " size_valid count"}, 64'(sv_cnt), 64'd0);
        check_eq({tag, " size held"}, 64'(size), 64'(last_size));
        check_eq({tag, " busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [SIZE_W-1:0] sz;
        int unsigned       n_edge;
        clr_mon();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("reset outputs",
                 64'({size, size_valid, data_start, data_out, data_valid, hdr_err, busy}), 64'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;

        pre_q.delete();
        run_frame("basic", 5, 1'b0);

        pre_q.delete();
        sz = 8'hA4;
        for (int k = 7; k >= 0; k--) pre_q.push_back(sz[k]);
        run_frame("false sync", 3, 1'b0);

        run_reject("zero size", '0, 1'b0);

        pre_q.delete();
        run_frame("gapped", 5, 1'b1);

        // Reset after 16 size bits.
        pre_q.delete();
        build_stream(SIZE_W'($urandom));
        for (int i = 0; i < SYNC_W + 16; i++) put_bit(s_q[i], 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check_eq("mid-size reset outputs",
                 64'({size, size_valid, data_start, data_out, data_valid, hdr_err, busy}), 64'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        last_size = '0;
        pre_q.delete();
        run_frame("after reset", 7, 1'b0);

`ifdef SIZE_HDR_PARITY_EN
        run_reject("bad parity", 5, 1'b1);
        pre_q.delete();
        run_frame("good parity", 5, 1'b0);
`endif

        for (int r = 0; r < 6; r++) begin
            sz = SIZE_W'($urandom_range(1, 24));
            make_prefix(12, sz);
            run_frame("random", sz, 1'($urandom));
        end

        // Mid-payload reset: start a frame, reset part way through the payload.
        pre_q.delete();
        build_stream(SIZE_W'(10));
        clr_mon();
        send_header(1'b0, 1'b0, n_edge);
        repeat (4) drive(1'($urandom), 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check_eq("mid-payload reset outputs",
                 64'({size, size_valid, data_start, data_out, data_valid, hdr_err, busy}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/size_header_rx.md
# size_header_rx

Upstream neighbour of `size_count`. Hunts a serial bitstream for a sync word, deserializes the 32-bit payload size that follows, and presents it to `size_count` as `size`/`size_valid`. It then raises `data_start` and forwards payload bits until `size_count` returns `last`, after which it re-arms the hunt.

## Interface
- `SYNC_W`, 8: width of the sync word.
- `SYNC_WORD`, 8'hA5: sync pattern, MSB first on the wire.
- `SIZE_W`, 32: width of the size field, matching `size_count`.
- `clock` input 1: sole clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `serial_in` input 1: incoming bit, sampled only when `serial_valid`=1.
- `serial_valid` input 1: qualifies `serial_in`.
- `last` input 1: from `size_count`; ends the payload.
- `size` output SIZE_W: deserialized size; held until the next header completes.
- `size_valid` output 1: one-cycle pulse; `size` is valid in that cycle.
- `data_start` output 1: level, high for the whole payload phase.
- `data_out` output 1: payload bit (`serial_in` registered).
- `data_valid` output 1: `serial_valid` registered, gated to the payload phase.
- `hdr_err` output 1: one-cycle pulse on a rejected header.
- `busy` output 1: high in any state other than HUNT.

## Operation
- States: HUNT, SIZE, (PARITY), ISSUE, PAYLOAD.
- **HUNT**
  - Each valid bit shifts left into the SYNC_W sync register.
  - When the register value including the current bit equals SYNC_WORD, move to SIZE next cycle.
  - Invalid cycles do not shift.
- **SIZE**
  - Valid bits shift MSB first into the size shift register.
  - A 6-bit counter counts valid bits. After the SIZE_W-th bit, go to PARITY if compiled in, otherwise ISSUE.
- **ISSUE**, one cycle:
  - If the size value is 0: pulse `hdr_err`, leave `size` unchanged, return to HUNT.
  - Otherwise: load `size`, pulse `size_valid`, go to PAYLOAD.
- **PAYLOAD**
  - `data_start`=1.
  - Each valid bit appears on `data_out`/`data_valid` one cycle later.
  - When `last`=1 is sampled, the next state is HUNT and the sync register clears. A bit arriving in the same cycle as `last` is still forwarded.
- Sync detection is inactive outside HUNT. A sync pattern inside the payload is payload data.
- `last` outside PAYLOAD is ignored.
- No back-pressure. Bits arriving in ISSUE or PARITY-evaluation cycles are dropped; the upstream source must idle one cycle after the header.

## Timing
- Reset values: state HUNT, and all of `size`, `size_valid`, `data_start`, `data_out`, `data_valid`, `hdr_err`, `busy` are 0. Sync register, size register and counter are cleared.
- Reset in any state takes effect on the next edge, including mid-size and mid-payload. No partial `size` is ever published.
- Latency: last size bit sampled at edge N, `size_valid` high in cycle N+1, `data_start` high from N+2.
  - With parity: the parity bit is sampled at edge M, `size_valid` is high in cycle M+1, and `data_start` is high from M+2.
- `data_start` falls on the edge after `last` is sampled.
- `size_valid` and `data_start` are never high in the same cycle.
- With continuous `serial_valid`, a header is SYNC_W+SIZE_W bits and the payload begins SYNC_W+SIZE_W+2 cycles after the first sync bit.

## Configuration
- `SIZE_HDR_PARITY_EN` defined:
  - A PARITY state follows SIZE and consumes one valid bit as even parity over the SIZE_W size bits.
  - On mismatch, pulse `hdr_err` and return to HUNT without `size_valid`. On match, go to ISSUE.
- `SIZE_HDR_PARITY_EN` undefined: no PARITY state; SIZE goes directly to ISSUE.

## Structure
- Shared package `size_hdr_pkg`: state enum (HUNT, SIZE, PARITY, ISSUE, PAYLOAD), default SYNC_WORD, SYNC_W and SIZE_W constants. `size_count` benches import the same SIZE_W.
- One sub-module, `sync_detect`: the SYNC_W shift register and comparator, with inputs `clock`, `rst`, `clear`, `enable`, `bit_in` and output `match`.

## Test plan
- **Basic header:** reset, then A5 followed by 32'h00000005 MSB first, `serial_valid` continuous -> `size_valid` pulses once with `size`=5, and `data_start` rises one cycle later. Feed 5 bits and assert `last` on the 5th -> `data_start` falls and `busy`=0.
- **False sync:** stream 8'hA4, then A5, then size 3 -> only one `size_valid`, `size`=3, and none on the near-miss.
- **Zero size:** A5 then 32'h0 -> `hdr_err` pulses, no `size_valid`, `size` keeps its prior value, back in HUNT.
- **Gapped input:** same as the basic header with `serial_valid` toggling 1/0 -> identical `size`=5, and every payload bit appears on `data_out` exactly once.
- **Mid-operation reset:** assert `rst` after 16 size bits -> all outputs 0 next cycle; a fresh A5 + size 7 then yields `size`=7.
- **Parity:** with `SIZE_HDR_PARITY_EN`, send size 5 with parity bit 1 -> `hdr_err` pulses. Resend with parity bit 0 -> `size_valid` pulses with `size`=5.
